// File: rtl/siphash_pkg.sv
// Shared SipHash constants, FSM state encoding and the four-lane state type.
// Imported by the round datapath and by the engine.
package siphash_pkg;

    localparam logic [63:0] IV0 = 64'h736f6d6570736575;
    localparam logic [63:0] IV1 = 64'h646f72616e646f6d;
    localparam logic [63:0] IV2 = 64'h6c7967656e657261;
    localparam logic [63:0] IV3 = 64'h7465646279746573;

    localparam logic [63:0] LONG_INIT_XOR = 64'h00000000000000ee;
    localparam logic [63:0] FIN_LONG_XOR  = 64'h00000000000000ee;
    localparam logic [63:0] FIN_SHORT_XOR = 64'h00000000000000ff;
    localparam logic [63:0] FIN_MID_XOR   = 64'h00000000000000dd;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_COMP_LOOP = 3'd1;
    localparam logic [2:0] ST_COMP_END  = 3'd2;
    localparam logic [2:0] ST_FIN_LOOP  = 3'd3;
    localparam logic [2:0] ST_FIN_MID   = 3'd4;
    localparam logic [2:0] ST_FIN_LOOP2 = 3'd5;
    localparam logic [2:0] ST_FIN_END   = 3'd6;

    typedef struct packed {
        logic [63:0] v0;
        logic [63:0] v1;
        logic [63:0] v2;
        logic [63:0] v3;
    } sip_state_t;

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned n);
        return (x << n) | (x >> (64 - n));
    endfunction

endpackage

// File: rtl/siphash_round.sv
// One combinational SipRound over the four 64-bit lanes.
module siphash_round
    import siphash_pkg::*;
(
    input  sip_state_t v_in,
    output sip_state_t v_out
);

    logic [63:0] v0_a, v1_a, v2_a, v3_a;
    logic [63:0] v0_b, v1_b, v2_b, v3_b;

    // First half-round pairs (v0,v1) and (v2,v3); second half crosses them.
    assign v0_a = v_in.v0 + v_in.v1;
    assign v1_a = rotl64(v_in.v1, 13) ^ v0_a;
    assign v2_a = v_in.v2 + v_in.v3;
    assign v3_a = rotl64(v_in.v3, 16) ^ v2_a;

    assign v0_b = rotl64(v0_a, 32) + v3_a;
    assign v3_b = rotl64(v3_a, 21) ^ v0_b;
    assign v2_b = v2_a + v1_a;
    assign v1_b = rotl64(v1_a, 17) ^ v2_b;

    assign v_out.v0 = v0_b;
    assign v_out.v1 = v1_b;
    assign v_out.v2 = rotl64(v2_b, 32);
    assign v_out.v3 = v3_b;

endmodule

// File: rtl/siphash_engine.sv
// SipHash-c-d engine: word-at-a-time compression and 64/128-bit finalization,
// with ROUNDS_PER_CYCLE chained SipRounds per loop cycle.
module siphash_engine
    import siphash_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int MAX_ROUNDS_W     = 4
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    initialize,
    input  logic                    compress,
    input  logic                    finalize,
    input  logic                    long,
    input  logic [MAX_ROUNDS_W-1:0] compression_rounds,
    input  logic [MAX_ROUNDS_W-1:0] final_rounds,
    input  logic [127:0]            key,
    input  logic [63:0]             mi,
    output logic                    ready,
    output logic [127:0]            siphash_word,
    output logic                    siphash_word_valid
);

    localparam logic [MAX_ROUNDS_W-1:0] RPC = MAX_ROUNDS_W'(ROUNDS_PER_CYCLE);

    logic [2:0]              state_q, state_d;
    sip_state_t              v_q, v_d;
    logic [63:0]             mi_q, mi_d;
    logic [63:0]             w0_q, w0_d;
    logic [MAX_ROUNDS_W-1:0] cnt_q, cnt_d;
    logic [MAX_ROUNDS_W-1:0] d_rounds_q, d_rounds_d;
    logic                    long_q, long_d;
    logic [127:0]            word_q, word_d;
    logic                    valid_q, valid_d;

    logic [MAX_ROUNDS_W-1:0] cnt_after;
    logic [63:0]             lane_xor;
    sip_state_t              loop_out;

    // Stage gi runs only while more than gi rounds remain; otherwise it passes through.
    for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_stage
        localparam logic [MAX_ROUNDS_W-1:0] STAGE_IDX = MAX_ROUNDS_W'(gi);
        sip_state_t stage_in;
        sip_state_t rnd_out;
        sip_state_t stage_out;
        if (gi == 0) begin : g_first
            assign stage_in = v_q;
        end else begin : g_next
            assign stage_in = g_stage[gi-1].stage_out;
        end
        siphash_round u_round (
            .v_in  (stage_in),
            .v_out (rnd_out)
        );
        assign stage_out = (cnt_q > STAGE_IDX) ? rnd_out : stage_in;
    end

    assign loop_out  = g_stage[ROUNDS_PER_CYCLE-1].stage_out;
    assign cnt_after = (cnt_q > RPC) ? cnt_q - RPC : '0;
    assign lane_xor  = v_q.v0 ^ v_q.v1 ^ v_q.v2 ^ v_q.v3;

    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        mi_d       = mi_q;
        w0_d       = w0_q;
        cnt_d      = cnt_q;
        d_rounds_d = d_rounds_q;
        long_d     = long_q;
        word_d     = word_q;
        valid_d    = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (initialize) begin
                    v_d.v0  = key[63:0]   ^ IV0;
                    v_d.v1  = key[127:64] ^ IV1 ^ (long ? LONG_INIT_XOR : 64'h0);
                    v_d.v2  = key[63:0]   ^ IV2;
                    v_d.v3  = key[127:64] ^ IV3;
                    long_d  = long;
                    valid_d = 1'b0;
                end else if (compress) begin
                    mi_d    = mi;
                    v_d.v3  = v_q.v3 ^ mi;
                    cnt_d   = compression_rounds;
                    state_d = (compression_rounds == '0) ? ST_COMP_END : ST_COMP_LOOP;
                end else if (finalize) begin
                    v_d.v2     = v_q.v2 ^ (long_q ? FIN_LONG_XOR : FIN_SHORT_XOR);
                    cnt_d      = final_rounds;
                    d_rounds_d = final_rounds;
                    if (final_rounds != '0)
                        state_d = ST_FIN_LOOP;
                    else
                        state_d = long_q ? ST_FIN_MID : ST_FIN_END;
                end
            end
            ST_COMP_LOOP: begin
                v_d   = loop_out;
                cnt_d = cnt_after;
                if (cnt_after == '0)
                    state_d = ST_COMP_END;
            end
            ST_COMP_END: begin
                v_d.v0  = v_q.v0 ^ mi_q;
                state_d = ST_IDLE;
            end
            ST_FIN_LOOP, ST_FIN_LOOP2: begin
                v_d   = loop_out;
                cnt_d = cnt_after;
                if (cnt_after == '0)
                    state_d = (state_q == ST_FIN_LOOP && long_q) ? ST_FIN_MID : ST_FIN_END;
            end
            ST_FIN_MID: begin
                w0_d    = lane_xor;
                v_d.v1  = v_q.v1 ^ FIN_MID_XOR;
                cnt_d   = d_rounds_q;
                state_d = (d_rounds_q == '0) ? ST_FIN_END : ST_FIN_LOOP2;
            end
            ST_FIN_END: begin
                word_d  = long_q ? {lane_xor, w0_q} : {64'h0, lane_xor};
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            v_q        <= '0;
            mi_q       <= '0;
            w0_q       <= '0;
            cnt_q      <= '0;
            d_rounds_q <= '0;
            long_q     <= 1'b0;
            word_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            mi_q       <= mi_d;
            w0_q       <= w0_d;
            cnt_q      <= cnt_d;
            d_rounds_q <= d_rounds_d;
            long_q     <= long_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
        end
    end

    assign ready              = (state_q == ST_IDLE);
    assign siphash_word       = word_q;
    assign siphash_word_valid = valid_q;

endmodule
